// File: rtl/embedding_frame_loader_if.sv
// Stream bundle around the frame loader: element beats in, packed frames and error status out.
interface embedding_frame_loader_if #(
    parameter int N_ELEM = 10,
    parameter int ELEM_W = 4,
    parameter int ERR_W  = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ELEM_W-1:0]          in_a;
    logic [ELEM_W-1:0]          in_b;
    logic                       in_c;
    logic                       in_d;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_ELEM*ELEM_W-1:0]   vector_a;
    logic [N_ELEM*ELEM_W-1:0]   vector_b;
    logic [N_ELEM-1:0]          vector_c;
    logic [N_ELEM-1:0]          vector_d;
    logic                       frame_err;
    logic [ERR_W-1:0]           err_count;

    // Producer of beats and consumer of frames.
    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_last, out_ready,
        input  in_ready, out_valid, vector_a, vector_b, vector_c, vector_d,
               frame_err, err_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_last, out_ready,
        output in_ready, out_valid, vector_a, vector_b, vector_c, vector_d,
               frame_err, err_count
    );
endinterface

// File: rtl/embedding_frame_loader.sv
// Packs N_ELEM element beats into A/B/C/D vectors; a second frame may be collected
// while the presented one waits, and framing errors are pulsed and counted.
module embedding_frame_loader #(
    parameter int N_ELEM = 10,
    parameter int ELEM_W = 4,
    parameter int ERR_W  = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    embedding_frame_loader_if.slave  io
);
    localparam int IDX_W = $clog2(N_ELEM);
    localparam int VEC_W = N_ELEM * ELEM_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [VEC_W-1:0]   bufA_q,     bufA_d;
    logic [VEC_W-1:0]   bufB_q,     bufB_d;
    logic [N_ELEM-1:0]  bufC_q,     bufC_d;
    logic [N_ELEM-1:0]  bufD_q,     bufD_d;
    logic [VEC_W-1:0]   vecA_q,     vecA_d;
    logic [VEC_W-1:0]   vecB_q,     vecB_d;
    logic [N_ELEM-1:0]  vecC_q,     vecC_d;
    logic [N_ELEM-1:0]  vecD_q,     vecD_d;
    logic               outValid_q, outValid_d;
    logic               frameErr_q, frameErr_d;
    logic [ERR_W-1:0]   errCount_q, errCount_d;
    logic               slotFree;

    // Next-state logic: beat capture, frame completion, hand-off from the hold buffer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bufA_d     = bufA_q;
        bufB_d     = bufB_q;
        bufC_d     = bufC_q;
        bufD_d     = bufD_q;
        vecA_d     = vecA_q;
        vecB_d     = vecB_q;
        vecC_d     = vecC_q;
        vecD_d     = vecD_q;
        outValid_d = outValid_q;
        frameErr_d = 1'b0;
        errCount_d = errCount_q;
        slotFree   = !outValid_q || io.out_ready;

        if (outValid_q && io.out_ready) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (io.in_valid) begin
                    for (int i = 0; i < N_ELEM; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            bufA_d[i*ELEM_W +: ELEM_W] = io.in_a;
                            bufB_d[i*ELEM_W +: ELEM_W] = io.in_b;
                            bufC_d[i]                  = io.in_c;
                            bufD_d[i]                  = io.in_d;
                        end
                    end
                    // A frame is good only if in_last lands exactly on the final slot.
                    if (io.in_last != (idx_q == LAST_IDX)) begin
                        idx_d      = '0;
                        frameErr_d = 1'b1;
                        if (errCount_q != '1) begin
                            errCount_d = errCount_q + ERR_W'(1);
                        end
                    end else if (io.in_last) begin
                        idx_d = '0;
                        if (slotFree) begin
                            vecA_d     = bufA_d;
                            vecB_d     = bufB_d;
                            vecC_d     = bufC_d;
                            vecD_d     = bufD_d;
                            outValid_d = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (io.out_ready) begin
                    vecA_d     = bufA_q;
                    vecB_d     = bufB_q;
                    vecC_d     = bufC_q;
                    vecD_d     = bufD_q;
                    outValid_d = 1'b1;
                    state_d    = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State registers with synchronous active-low reset that drops any partial or pending frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            bufA_q     <= '0;
            bufB_q     <= '0;
            bufC_q     <= '0;
            bufD_q     <= '0;
            vecA_q     <= '0;
            vecB_q     <= '0;
            vecC_q     <= '0;
            vecD_q     <= '0;
            outValid_q <= 1'b0;
            frameErr_q <= 1'b0;
            errCount_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bufA_q     <= bufA_d;
            bufB_q     <= bufB_d;
            bufC_q     <= bufC_d;
            bufD_q     <= bufD_d;
            vecA_q     <= vecA_d;
            vecB_q     <= vecB_d;
            vecC_q     <= vecC_d;
            vecD_q     <= vecD_d;
            outValid_q <= outValid_d;
            frameErr_q <= frameErr_d;
            errCount_q <= errCount_d;
        end
    end

    assign io.in_ready  = (state_q == COLLECT);
    assign io.out_valid = outValid_q;
    assign io.vector_a  = vecA_q;
    assign io.vector_b  = vecB_q;
    assign io.vector_c  = vecC_q;
    assign io.vector_d  = vecD_q;
    assign io.frame_err = frameErr_q;
    assign io.err_count = errCount_q;

endmodule

// File: tb/tb_embedding_frame_loader.sv
// Randomized bench for embedding_frame_loader, checked against a frame-level queue model.
module tb_embedding_frame_loader;
    localparam int N = 10;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    embedding_frame_loader_if #(.N_ELEM(N), .ELEM_W(W), .ERR_W(8)) io ();

    embedding_frame_loader #(.N_ELEM(N), .ELEM_W(W), .ERR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int checks = 0;
    int failures = 0;
    int outMode = 0;
    bit monitorOn = 1'b0;

    logic [39:0] expQA[$];
    logic [39:0] expQB[$];
    logic [9:0]  expQC[$];
    logic [9:0]  expQD[$];
    logic [3:0]  mA[N];
    logic [3:0]  mB[N];
    logic        mC[N];
    logic        mD[N];
    int          mCount = 0;
    int          modelErrs = 0;
    bit          errPending = 1'b0;
    int          framesOut = 0;
    logic [39:0] pA, pB;
    logic [9:0]  pC, pD;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one beat and hold it until the loader accepts it.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic c,
                                 input logic d, input logic last);
        int waitCnt = 0;
        io.in_a = a;
        io.in_b = b;
        io.in_c = c;
        io.in_d = d;
        io.in_last = last;
        io.in_valid = 1'b1;
        @(negedge clk);
        while (!io.in_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!io.in_ready) checkOutput("in_ready_timeout", 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic sendFrame(input int nBeats, input bit finalLast, input bit randomData, input bit bubbles);
        logic [3:0] a, b;
        logic c, d;
        for (int i = 0; i < nBeats; i++) begin
            if (bubbles) begin
                int gap = $urandom_range(0, 3);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (randomData) begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                c = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
            end else begin
                a = 4'(i + 1);
                b = 4'd2;
                c = (i % 2 == 0);
                d = 1'b1;
            end
            applyStimulus(a, b, c, d, finalLast && (i == nBeats - 1));
        end
    endtask

    task automatic checkPattern1(input string pfx);
        checkOutput($sformatf("%s_vector_a", pfx), 64'(io.vector_a), 64'h00_0000_00A9_8765_4321 & 64'hFF_FFFF_FFFF);
        checkOutput($sformatf("%s_vector_b", pfx), 64'(io.vector_b), 64'h22_2222_2222);
        checkOutput($sformatf("%s_vector_c", pfx), 64'(io.vector_c), 64'h155);
        checkOutput($sformatf("%s_vector_d", pfx), 64'(io.vector_d), 64'h3FF);
    endtask

    // Consumer ready: 0 = always ready, 1 = stalled, otherwise random.
    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (outMode)
                0:       io.out_ready = 1'b1;
                1:       io.out_ready = 1'b0;
                default: io.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Frame-level reference model: a queue of completed frames awaiting consumption.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("out_valid", 64'(io.out_valid), 64'(expQA.size() > 0));
            checkOutput("in_ready", 64'(io.in_ready), 64'(expQA.size() < 2));
            checkOutput("frame_err", 64'(io.frame_err), 64'(errPending));
            checkOutput("err_count", 64'(io.err_count), 64'(modelErrs));
            if (!rst_n) begin
                expQA.delete();
                expQB.delete();
                expQC.delete();
                expQD.delete();
                mCount = 0;
                modelErrs = 0;
                errPending = 1'b0;
            end else begin
                errPending = 1'b0;
                if (io.out_valid && io.out_ready) begin
                    framesOut++;
                    if (expQA.size() == 0) begin
                        checkOutput("unexpected_frame", 64'd1, 64'd0);
                    end else begin
                        checkOutput("frame_vector_a", 64'(io.vector_a), 64'(expQA.pop_front()));
                        checkOutput("frame_vector_b", 64'(io.vector_b), 64'(expQB.pop_front()));
                        checkOutput("frame_vector_c", 64'(io.vector_c), 64'(expQC.pop_front()));
                        checkOutput("frame_vector_d", 64'(io.vector_d), 64'(expQD.pop_front()));
                    end
                end
                if (io.in_valid && io.in_ready) begin
                    mA[mCount] = io.in_a;
                    mB[mCount] = io.in_b;
                    mC[mCount] = io.in_c;
                    mD[mCount] = io.in_d;
                    mCount++;
                    if (io.in_last != (mCount == N)) begin
                        errPending = 1'b1;
                        if (modelErrs < 255) modelErrs++;
                        mCount = 0;
                    end else if (mCount == N) begin
                        pA = '0; pB = '0; pC = '0; pD = '0;
                        for (int i = 0; i < N; i++) begin
                            pA = pA | (40'(mA[i]) << (W * i));
                            pB = pB | (40'(mB[i]) << (W * i));
                            pC = pC | (10'(mC[i]) << i);
                            pD = pD | (10'(mD[i]) << i);
                        end
                        expQA.push_back(pA);
                        expQB.push_back(pB);
                        expQC.push_back(pC);
                        expQD.push_back(pD);
                        mCount = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int cnt;
        io.in_valid = 1'b0;
        io.in_a = '0;
        io.in_b = '0;
        io.in_c = 1'b0;
        io.in_d = 1'b0;
        io.in_last = 1'b0;
        @(posedge clk);
        #1;
        monitorOn = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(io.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(io.in_ready), 64'd1);
        checkOutput("rst_vector_a", 64'(io.vector_a), 64'd0);
        checkOutput("rst_vector_c", 64'(io.vector_c), 64'd0);
        checkOutput("rst_err_count", 64'(io.err_count), 64'd0);

        @(posedge clk); #1;
        sendFrame(10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s1_out_valid", 64'(io.out_valid), 64'd1);
        checkPattern1("s1");

        outMode = 1;
        @(posedge clk); #1;
        sendFrame(10, 1'b1, 1'b1, 1'b0);
        sendFrame(10, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s2_hold_in_ready", 64'(io.in_ready), 64'd0);
        checkOutput("s2_hold_out_valid", 64'(io.out_valid), 64'd1);
        outMode = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("s2_release_in_ready", 64'(io.in_ready), 64'd1);
        checkOutput("s2_release_out_valid", 64'(io.out_valid), 64'd1);
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end

        sendFrame(4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s3_frame_err", 64'(io.frame_err), 64'd1);
        checkOutput("s3_err_count", 64'(io.err_count), 64'd1);
        checkOutput("s3_out_valid", 64'(io.out_valid), 64'd0);
        @(negedge clk);
        checkOutput("s3_frame_err_clear", 64'(io.frame_err), 64'd0);
        @(posedge clk); #1;
        sendFrame(10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkPattern1("s3");

        @(posedge clk); #1;
        sendFrame(10, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s4_frame_err", 64'(io.frame_err), 64'd1);
        checkOutput("s4_err_count", 64'(io.err_count), 64'd2);
        @(posedge clk); #1;
        repeat (300) sendFrame(10, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s4_err_saturated", 64'(io.err_count), 64'hFF);

        @(posedge clk); #1;
        sendFrame(5, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("s5_vector_a", 64'(io.vector_a), 64'd0);
        checkOutput("s5_vector_b", 64'(io.vector_b), 64'd0);
        checkOutput("s5_vector_c", 64'(io.vector_c), 64'd0);
        checkOutput("s5_vector_d", 64'(io.vector_d), 64'd0);
        checkOutput("s5_out_valid", 64'(io.out_valid), 64'd0);
        checkOutput("s5_err_count", 64'(io.err_count), 64'd0);
        @(posedge clk); #1;
        sendFrame(10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkPattern1("s5");

        outMode = 2;
        @(posedge clk); #1;
        base = framesOut;
        for (int k = 0; k < 20; k++) begin
            sendFrame(10, 1'b1, (k % 4 != 0), 1'b1);
        end
        outMode = 0;
        cnt = 0;
        @(negedge clk);
        while (expQA.size() > 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        checkOutput("s6_drain_empty", 64'(expQA.size()), 64'd0);
        checkOutput("s6_frames_out", 64'(framesOut - base), 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
